// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_pkg
// Purpose  : Shared defaults and state encoding for the Viterbi traceback
//            block and its backpointer memory.
// Contents : c_word_num / c_word_num_bit  - sentence length and index width
//            c_pos_num  / c_pos_num_bit   - POS state count and index width
//            tb_state_t                   - IDLE (filling) / TRACE
// Revision : 1.0 - initial release
// ============================================================================
package viterbi_pkg;

    localparam int c_word_num     = 16;
    localparam int c_word_num_bit = 4;
    localparam int c_pos_num      = 11;
    localparam int c_pos_num_bit  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        TRACE = 1'b1
    } tb_state_t;

endpackage : viterbi_pkg
`default_nettype wire

// File: rtl/viterbi_tb_mem.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_tb_mem
// Purpose  : Backpointer register file, one row per word, one encoded
//            predecessor slice per POS state. Synchronous write,
//            combinational read. Contents are intentionally not reset.
// Ports    : clk      - clock
//            i_we     - write enable
//            i_waddr  - write row
//            i_wdata  - row data (POS_num slices of POS_num_bit bits)
//            i_raddr  - read row
//            o_rdata  - row data at i_raddr
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_tb_mem
    import viterbi_pkg::*;
#(
    parameter int word_num     = c_word_num,
    parameter int word_num_bit = c_word_num_bit,
    parameter int POS_num      = c_pos_num,
    parameter int POS_num_bit  = c_pos_num_bit
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic [word_num_bit-1:0]        i_waddr,
    input  logic [POS_num*POS_num_bit-1:0] i_wdata,
    input  logic [word_num_bit-1:0]        i_raddr,
    output logic [POS_num*POS_num_bit-1:0] o_rdata
);

    logic [POS_num*POS_num_bit-1:0] r_mem [word_num];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : viterbi_tb_mem
`default_nettype wire

// File: rtl/viterbi_traceback.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_traceback
// Purpose  : Collects per-word backpointer vectors for one sentence, then
//            walks them backwards from the best final state, emitting one
//            POS tag per cycle (last word first, word 0 flagged tag_last).
// Ports    : clk, reset (async, active low)
//            bp_in/bp_valid/bp_ready  - backpointer beat stream
//            seq_last, final_state    - sentence end marker and best state
//            tag_data/tag_idx/tag_valid/tag_ready/tag_last - tag stream
//            err                      - sticky overflow flag (optional)
// Options  : VITERBI_TB_ERR_EN - adds the err output and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int word_num     = c_word_num,
    parameter int word_num_bit = c_word_num_bit,
    parameter int POS_num      = c_pos_num,
    parameter int POS_num_bit  = c_pos_num_bit
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [POS_num*POS_num_bit-1:0] bp_in,
    input  logic                           bp_valid,
    output logic                           bp_ready,
    input  logic                           seq_last,
    input  logic [POS_num_bit-1:0]         final_state,
    output logic [POS_num_bit-1:0]         tag_data,
    output logic [word_num_bit-1:0]        tag_idx,
    output logic                           tag_valid,
    input  logic                           tag_ready,
    output logic                           tag_last
`ifdef VITERBI_TB_ERR_EN
    ,
    output logic                           err
`endif
);

    // wcnt needs one extra bit so that "full" (== word_num) is representable.
    localparam logic [word_num_bit:0]   c_wcnt_max = (word_num_bit+1)'(word_num);
    localparam logic [word_num_bit-1:0] c_k_max    = word_num_bit'(word_num - 1);

    tb_state_t                      r_state;
    logic [word_num_bit:0]          r_wcnt;
    logic [word_num_bit-1:0]        r_k;
    logic [POS_num_bit-1:0]         r_cur;
    logic                           r_tag_valid;
    logic                           r_tag_last;

    logic                           w_accept;
    logic                           w_has_room;
    logic [word_num_bit-1:0]        w_k_load;
    logic [POS_num*POS_num_bit-1:0] w_row;
    logic [POS_num_bit-1:0]         w_pred;

    assign w_accept   = bp_valid && (r_state == IDLE);
    assign w_has_room = (r_wcnt < c_wcnt_max);
    assign w_k_load   = w_has_room ? r_wcnt[word_num_bit-1:0] : c_k_max;

    viterbi_tb_mem #(
        .word_num     (word_num),
        .word_num_bit (word_num_bit),
        .POS_num      (POS_num),
        .POS_num_bit  (POS_num_bit)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_accept && w_has_room),
        .i_waddr (r_wcnt[word_num_bit-1:0]),
        .i_wdata (bp_in),
        .i_raddr (r_k),
        .o_rdata (w_row)
    );

    // Predecessor lookup by compare-and-select: a state index with no slice
    // (cur >= POS_num) matches nothing and falls through to 0.
    always_comb begin
        w_pred = '0;
        for (int s = 0; s < POS_num; s++) begin
            if (r_cur == POS_num_bit'(s)) begin
                w_pred = w_row[s*POS_num_bit +: POS_num_bit];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wcnt      <= '0;
            r_k         <= '0;
            r_cur       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_has_room) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                        if (seq_last) begin
                            r_cur       <= final_state;
                            r_k         <= w_k_load;
                            r_tag_last  <= (w_k_load == '0);
                            r_tag_valid <= 1'b1;
                            r_state     <= TRACE;
                        end
                    end
                end
                TRACE: begin
                    if (tag_ready) begin
                        if (r_k != '0) begin
                            r_cur      <= w_pred;
                            r_k        <= r_k - 1'b1;
                            r_tag_last <= (r_k == word_num_bit'(1));
                        end else begin
                            r_tag_valid <= 1'b0;
                            r_tag_last  <= 1'b0;
                            r_wcnt      <= '0;
                            r_state     <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef VITERBI_TB_ERR_EN
    // Sticky: any beat arriving with the memory already full is an overflow,
    // whether it is discarded or only contributes its final_state.
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_has_room) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign bp_ready  = (r_state == IDLE);
    assign tag_valid = r_tag_valid;
    assign tag_data  = r_cur;
    assign tag_idx   = r_k;
    assign tag_last  = r_tag_last;

endmodule : viterbi_traceback
`default_nettype wire
